// File: rtl/mux4x1_rr_arbiter_if.sv
// Lane bundle for the 4:1 round-robin arbitrated mux: requests/data in, grant and lane output back.
interface mux4x1_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] data;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       gnt_valid;
    logic       out;
    logic       preempt;

    modport master (
        output req, data,
        input  gnt, sel, gnt_valid, out, preempt
    );

    modport slave (
        input  req, data,
        output gnt, sel, gnt_valid, out, preempt
    );
endinterface

// File: rtl/mux4x1_rr_arbiter.sv
// Round-robin arbiter for a shared one-bit 4:1 lane: bounded tenures, one dead cycle between owners,
// registered grant/select and registered lane output.
module mux4x1_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux4x1_rr_arbiter_if.slave   lane_io
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             preempt_q, preempt_d;
    logic             out_q, out_d;

    logic [3:0]       req_c;
    logic [3:0]       data_c;
    logic             found;
    logic [1:0]       win;

    // Unknown request/data bits are forced to 0 so they can never steer the state.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_clean
            assign req_c[gi]  = (lane_io.req[gi]  === 1'b1);
            assign data_c[gi] = (lane_io.data[gi] === 1'b1);
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!found && req_c[ptr_q + 2'(k)]) begin
                found = 1'b1;
                win   = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        out_d     = (|gnt_q) ? data_c[sel_q] : 1'b0;

        case (state_q)
            IDLE, GAP: begin
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    hold_d  = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                end
            end
            GRANT: begin
                // A voluntary drop outranks the timeout, so preempt only flags true forced releases.
                if (!req_c[sel_q] || (hold_q == HOLD_LAST)) begin
                    state_d   = GAP;
                    gnt_d     = 4'b0000;
                    ptr_d     = sel_q + 2'd1;
                    preempt_d = req_c[sel_q];
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            ptr_q     <= 2'd0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
            out_q     <= out_d;
        end
    end

    assign lane_io.gnt       = gnt_q;
    assign lane_io.sel       = sel_q;
    assign lane_io.gnt_valid = |gnt_q;
    assign lane_io.out       = out_q;
    assign lane_io.preempt   = preempt_q;
endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// Directed and randomized checks of the round-robin lane arbiter at MAX_HOLD=8 (ifa) and MAX_HOLD=2 (ifb).
module tb_mux4x1_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_v = 4'b0000;
    logic [3:0] data_v = 4'b0000;
    int         checks = 0;
    int         failures = 0;

    mux4x1_rr_arbiter_if ifa ();
    mux4x1_rr_arbiter_if ifb ();

    assign ifa.req  = req_v;
    assign ifa.data = data_v;
    assign ifb.req  = req_v;
    assign ifb.data = data_v;

    mux4x1_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .lane_io(ifa));
    mux4x1_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .lane_io(ifb));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n  = 1'b0;
        req_v  = 4'b0000;
        data_v = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        req_v  = 4'b1111;
        data_v = 4'b1111;
        tick();
        checks++;
        if ({ifa.gnt, ifa.sel, ifa.gnt_valid, ifa.out, ifa.preempt} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b sel=%0d gv=%b out=%b pre=%b exp all zero",
                     ifa.gnt, ifa.sel, ifa.gnt_valid, ifa.out, ifa.preempt);
        end
        tick();
        checks++;
        if (ifb.gnt !== 4'b0000 || ifb.gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got gnt=%b gv=%b exp 0000/0", ifb.gnt, ifb.gnt_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_hold_timeout;
        do_reset();
        req_v = 4'b0100;
        tick();
        checks++;
        if (ifa.gnt !== 4'b0100 || ifa.sel !== 2'd2 || ifa.gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL t1_first_grant got gnt=%b sel=%0d gv=%b exp 0100/2/1", ifa.gnt, ifa.sel, ifa.gnt_valid);
        end
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++;
            if (ifa.gnt !== 4'b0100 || ifa.preempt !== 1'b0) begin
                failures++;
                $display("FAIL t1_hold cycle %0d got gnt=%b pre=%b exp 0100/0", i, ifa.gnt, ifa.preempt);
            end
        end
        tick();
        checks++;
        if (ifa.gnt !== 4'b0000 || ifa.preempt !== 1'b1 || ifa.gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL t1_timeout got gnt=%b pre=%b gv=%b exp 0000/1/0", ifa.gnt, ifa.preempt, ifa.gnt_valid);
        end
        tick();
        checks++;
        if (ifa.gnt !== 4'b0100 || ifa.sel !== 2'd2 || ifa.preempt !== 1'b0) begin
            failures++;
            $display("FAIL t1_regrant got gnt=%b sel=%0d pre=%b exp 0100/2/0", ifa.gnt, ifa.sel, ifa.preempt);
        end
        req_v = 4'b0000;
        $display("test_hold_timeout done");
    endtask

    task automatic test_rr_order;
        int         order[5];
        logic [3:0] exp_g;
        order = '{0, 1, 2, 3, 0};
        do_reset();
        req_v = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_g = 4'b0001 << order[n];
            tick();
            checks++;
            if (ifb.gnt !== exp_g || ifb.sel !== 2'(order[n])) begin
                failures++;
                $display("FAIL t2_grant tenure %0d got gnt=%b sel=%0d exp %b/%0d", n, ifb.gnt, ifb.sel, exp_g, order[n]);
            end
            tick();
            checks++;
            if (ifb.gnt !== exp_g || ifb.preempt !== 1'b0) begin
                failures++;
                $display("FAIL t2_second tenure %0d got gnt=%b pre=%b exp %b/0", n, ifb.gnt, ifb.preempt, exp_g);
            end
            tick();
            checks++;
            if (ifb.gnt !== 4'b0000 || ifb.preempt !== 1'b1) begin
                failures++;
                $display("FAIL t2_gap tenure %0d got gnt=%b pre=%b exp 0000/1", n, ifb.gnt, ifb.preempt);
            end
        end
        req_v = 4'b0000;
        $display("test_rr_order done");
    endtask

    task automatic test_early_release;
        do_reset();
        req_v = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ifa.gnt !== 4'b0010 || ifa.sel !== 2'd1) begin
                failures++;
                $display("FAIL t3_owner1 cycle %0d got gnt=%b sel=%0d exp 0010/1", i, ifa.gnt, ifa.sel);
            end
        end
        req_v = 4'b1000;
        tick();
        checks++;
        if (ifa.gnt !== 4'b0000 || ifa.preempt !== 1'b0 || ifa.sel !== 2'd1) begin
            failures++;
            $display("FAIL t3_gap got gnt=%b pre=%b sel=%0d exp 0000/0/1", ifa.gnt, ifa.preempt, ifa.sel);
        end
        tick();
        checks++;
        if (ifa.gnt !== 4'b1000 || ifa.sel !== 2'd3 || ifa.preempt !== 1'b0) begin
            failures++;
            $display("FAIL t3_next got gnt=%b sel=%0d pre=%b exp 1000/3/0", ifa.gnt, ifa.sel, ifa.preempt);
        end
        req_v = 4'b0000;
        $display("test_early_release done");
    endtask

    task automatic test_out;
        do_reset();
        req_v  = 4'b0010;
        data_v = 4'b0010;
        tick();
        checks++;
        if (ifa.gnt !== 4'b0010 || ifa.out !== 1'b0) begin
            failures++;
            $display("FAIL t4_out_lag got gnt=%b out=%b exp 0010/0", ifa.gnt, ifa.out);
        end
        tick();
        checks++;
        if (ifa.out !== 1'b1) begin
            failures++;
            $display("FAIL t4_out_high got out=%b exp 1", ifa.out);
        end
        data_v = 4'b1101;
        tick();
        checks++;
        if (ifa.out !== 1'b0) begin
            failures++;
            $display("FAIL t4_out_follow0 got out=%b exp 0", ifa.out);
        end
        data_v = 4'b0010;
        tick();
        checks++;
        if (ifa.out !== 1'b1) begin
            failures++;
            $display("FAIL t4_out_follow1 got out=%b exp 1", ifa.out);
        end
        req_v = 4'b0000;
        tick();
        checks++;
        if (ifa.gnt !== 4'b0000 || ifa.out !== 1'b1) begin
            failures++;
            $display("FAIL t4_release_edge got gnt=%b out=%b exp 0000/1", ifa.gnt, ifa.out);
        end
        tick();
        checks++;
        if (ifa.out !== 1'b0) begin
            failures++;
            $display("FAIL t4_out_clear got out=%b exp 0", ifa.out);
        end
        data_v = 4'b0000;
        $display("test_out done");
    endtask

    task automatic test_async_reset;
        do_reset();
        req_v  = 4'b1000;
        data_v = 4'b1000;
        tick();
        checks++;
        if (ifa.gnt !== 4'b1000 || ifa.sel !== 2'd3) begin
            failures++;
            $display("FAIL t5_grant3 got gnt=%b sel=%0d exp 1000/3", ifa.gnt, ifa.sel);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({ifa.gnt, ifa.sel, ifa.out, ifa.preempt, ifa.gnt_valid} !== 9'b0) begin
            failures++;
            $display("FAIL t5_async_clear got gnt=%b sel=%0d out=%b pre=%b gv=%b exp all zero",
                     ifa.gnt, ifa.sel, ifa.out, ifa.preempt, ifa.gnt_valid);
        end
        req_v = 4'b1001;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (ifa.gnt !== 4'b0001 || ifa.sel !== 2'd0) begin
            failures++;
            $display("FAIL t5_ptr_restart got gnt=%b sel=%0d exp 0001/0", ifa.gnt, ifa.sel);
        end
        req_v  = 4'b0000;
        data_v = 4'b0000;
        $display("test_async_reset done");
    endtask

    task automatic test_random;
        logic [3:0] g[2];
        logic [1:0] s[2];
        logic       gv[2];
        logic       pe[2];
        logic [3:0] prev_g[2];
        int         run[2];
        int         maxh[2];
        int         starve[2][4];
        logic [3:0] r;
        logic       new_start;
        maxh[0] = 8;
        maxh[1] = 2;
        for (int k = 0; k < 2; k++) begin
            prev_g[k] = 4'b0000;
            run[k]    = 0;
            for (int i = 0; i < 4; i++) starve[k][i] = 0;
        end
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) req_v[b] = ~req_v[b];
            end
            data_v = 4'($urandom);
            r = req_v;
            tick();
            g[0] = ifa.gnt; s[0] = ifa.sel; gv[0] = ifa.gnt_valid; pe[0] = ifa.preempt;
            g[1] = ifb.gnt; s[1] = ifb.sel; gv[1] = ifb.gnt_valid; pe[1] = ifb.preempt;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ((g[k] & 4'(g[k] - 4'd1)) != 4'b0000 || gv[k] !== (|g[k])) begin
                    failures++;
                    $display("FAIL rnd_onehot lane %0d cycle %0d got gnt=%b gv=%b", k, cyc, g[k], gv[k]);
                end
                if (g[k] != 4'b0000) begin
                    checks++;
                    if (g[k] !== (4'b0001 << s[k])) begin
                        failures++;
                        $display("FAIL rnd_sel lane %0d cycle %0d got sel=%0d gnt=%b", k, cyc, s[k], g[k]);
                    end
                end
                checks++;
                if (prev_g[k] != 4'b0000 && g[k] != 4'b0000 && g[k] != prev_g[k]) begin
                    failures++;
                    $display("FAIL rnd_gap lane %0d cycle %0d got gnt %b after %b exp a zero cycle", k, cyc, g[k], prev_g[k]);
                end
                if (pe[k]) begin
                    checks++;
                    if (g[k] != 4'b0000 || run[k] != maxh[k]) begin
                        failures++;
                        $display("FAIL rnd_preempt lane %0d cycle %0d got gnt=%b tenure=%0d exp 0000/%0d", k, cyc, g[k], run[k], maxh[k]);
                    end
                end
                new_start = (g[k] != 4'b0000) && (prev_g[k] == 4'b0000);
                for (int i = 0; i < 4; i++) begin
                    if (!r[i]) starve[k][i] = 0;
                    else if (new_start) begin
                        if (g[k][i]) starve[k][i] = 0;
                        else begin
                            starve[k][i]++;
                            checks++;
                            if (starve[k][i] > 3) begin
                                failures++;
                                $display("FAIL rnd_starve lane %0d cycle %0d req %0d waited %0d tenures exp <=3", k, cyc, i, starve[k][i]);
                            end
                        end
                    end
                end
                if (g[k] != 4'b0000) run[k]++;
                else run[k] = 0;
                checks++;
                if (run[k] > maxh[k]) begin
                    failures++;
                    $display("FAIL rnd_tenure lane %0d cycle %0d got %0d cycles exp <=%0d", k, cyc, run[k], maxh[k]);
                end
                prev_g[k] = g[k];
            end
        end
        req_v = 4'b0000;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_hold_timeout();
        test_rr_order();
        test_early_release();
        test_out();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
